// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, port id and
// the default WAIT timeout.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_e;

  typedef logic port_id_t;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between a fetch port (0) and a data port (1) in front of
// a single memory controller; one outstanding transaction at a time.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_data_in,
  input  logic                  p0_r_en,
  input  logic                  p0_w_en,
  output logic                  p0_ack,
  output logic                  p0_cplt,
  output logic [DATA_WIDTH-1:0] p0_data_out,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_data_in,
  input  logic                  p1_r_en,
  input  logic                  p1_w_en,
  output logic                  p1_ack,
  output logic                  p1_cplt,
  output logic [DATA_WIDTH-1:0] p1_data_out,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_r_en,
  output logic                  mem_w_en,
  input  logic                  mem_rdy,
  input  logic                  mem_cplt,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  timeout_err
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e                  state_q;
  port_id_t                last_grant_q;
  port_id_t                owner_q;
  logic                    write_q;
  logic [7:0]              cnt_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    mem_r_en_q;
  logic                    mem_w_en_q;
  logic [1:0]              ack_q;
  logic [1:0]              cplt_q;
  logic [DATA_WIDTH-1:0]   dout0_q;
  logic [DATA_WIDTH-1:0]   dout1_q;
  logic                    timeout_err_q;

  logic                    req0;
  logic                    req1;
  port_id_t                grant_d;
  logic                    wr_d;
  logic [ADDR_WIDTH-1:0]   addr_d;
  logic [DATA_WIDTH-1:0]   wdata_d;

  assign req0 = p0_r_en | p0_w_en;
  assign req1 = p1_r_en | p1_w_en;

  // Port 1 wins when it is alone, or on a tie when port 0 was granted last.
  always_comb begin
    grant_d = req1 & (~req0 | ~last_grant_q);
    wr_d    = grant_d ? p1_w_en    : p0_w_en;
    addr_d  = grant_d ? p1_addr    : p0_addr;
    wdata_d = grant_d ? p1_data_in : p0_data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      owner_q       <= 1'b0;
      write_q       <= 1'b0;
      cnt_q         <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      mem_r_en_q    <= 1'b0;
      mem_w_en_q    <= 1'b0;
      ack_q         <= '0;
      cplt_q        <= '0;
      dout0_q       <= '0;
      dout1_q       <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      ack_q  <= '0;
      cplt_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (req0 | req1) begin
            owner_q        <= grant_d;
            last_grant_q   <= grant_d;
            write_q        <= wr_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            mem_r_en_q     <= ~wr_d;
            mem_w_en_q     <= wr_d;
            ack_q[grant_d] <= 1'b1;
            state_q        <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_rdy) begin
            mem_r_en_q <= 1'b0;
            mem_w_en_q <= 1'b0;
            cnt_q      <= '0;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          if (mem_cplt) begin
            cplt_q[owner_q] <= 1'b1;
            if (!write_q) begin
              if (owner_q) dout1_q <= mem_data_out;
              else         dout0_q <= mem_data_out;
            end
            state_q <= IDLE;
          end else if (cnt_q == TO_LAST) begin
            // Abort: report all-ones data so the client can tell it was not served.
            cplt_q[owner_q] <= 1'b1;
            if (owner_q) dout1_q <= '1;
            else         dout0_q <= '1;
            timeout_err_q <= 1'b1;
            state_q       <= IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign p0_ack      = ack_q[0];
  assign p1_ack      = ack_q[1];
  assign p0_cplt     = cplt_q[0];
  assign p1_cplt     = cplt_q[1];
  assign p0_data_out = dout0_q;
  assign p1_data_out = dout1_q;
  assign mem_addr    = addr_q;
  assign mem_data_in = wdata_q;
  assign mem_r_en    = mem_r_en_q;
  assign mem_w_en    = mem_w_en_q;
  assign timeout_err = timeout_err_q;

endmodule
